demux_deserializer: RTL
=======================

Name: demux_deserializer

Overview:
- Downstream consumer of the 1x4 demultiplexer (Dmux).
- Samples the demux outputs y[3:0] with the select s[1:0] and a qualifying strobe, then reassembles each of the four channels' serial bit streams into WIDTH-bit words.
- Completed words are buffered one deep per channel and handed to a single valid/ready output through a round-robin arbiter.
- Flags overflow per channel and flags demux protocol errors.

Parameters:
WIDTH, 8, bits per assembled word (>=2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-high reset
in_valid  input  1  y/s carry a valid bit this cycle
s  input  2  channel select driven to the demux
y  input  4  demux outputs; y[s] is the data bit
out_ready  input  1  downstream accepts word
out_valid  output  1  out_data/out_ch valid
out_ch  output  2  source channel of out_data
out_data  output  WIDTH  assembled word
overflow  output  4  sticky per-channel word-drop flag
err  output  1  sticky protocol error

Behaviour:
- Reset (clk edge with rst=1): all counters = 0, partial words discarded, pend[3:0] = 0, rr = 0, out_valid = 0, out_ch = 0, out_data = 0, overflow = 0, err = 0. rst has priority over every other input.
- Per channel c, the block holds:
  - a shift register and bit counter cnt[c] (0..WIDTH-1);
  - a holding register hold[c] with a pending flag pend[c].
- Bit capture, on an edge with in_valid=1:
  - Bit b = y[s] goes to channel s, LSB first: the k-th received bit becomes word bit k.
  - cnt[s] increments.
  - Other channels are untouched.
- in_valid=0: no state changes in capture logic; y and s are ignored.
- Word completion occurs when cnt[s]==WIDTH-1 and a bit is captured:
  - cnt[s] returns to 0.
  - The full word goes to hold[s] and pend[s] is set on that same edge.
  - If pend[s] is already 1 and hold[s] is not popped on that edge, the new word is dropped, overflow[s] is set (sticky), and hold[s] keeps its old word.
  - If hold[s] is popped on the same edge, the new word is accepted without overflow.
- Protocol check: on in_valid=1, if any y[j]=1 for j != s, err is set (sticky) on that edge. Capture still uses y[s].
- Output register loads on any edge where (!out_valid || out_ready):
  - If any pend bit is set, the arbiter picks channel c: the first set pend bit searching rr, rr+1, ... mod 4.
  - The register loads out_data = hold[c], out_ch = c, out_valid = 1. pend[c] clears ("pop"), and rr becomes c+1 mod 4.
  - If no pend bit is set, out_valid goes to 0 and out_data/out_ch hold their last values.
- While out_valid=1 and out_ready=0, out_valid, out_ch and out_data are held stable.
- Latency: last bit captured on edge t; pend set at t; out_valid=1 after edge t+1 if the output register is free.
- Throughput: one word per cycle on output.
- At most one channel completes per cycle, so completions never collide.
- Reset mid-word: partial bits are lost; the next word on that channel starts from bit 0.

Test Plan:
1. WIDTH=8, s=2, in_valid=1 for 8 cycles, y[2] carries 0xA5 LSB first (other y bits 0), out_ready=1 -> out_valid=1 exactly one cycle after the last-bit edge, out_ch=2, out_data=0xA5, err=0, overflow=0.
2. Interleave s=0/1 each cycle, ch0 sends 0x3C and ch1 sends 0xC3 -> two transfers: ch0 0x3C then ch1 0xC3 on consecutive cycles.
3. out_ready=0; complete ch0 0x11, then ch1 0x22, then ch2 0x33 -> out holds ch0/0x11 stable. Raise out_ready -> ch1/0x22 then ch2/0x33 on the next two cycles, then out_valid=0.
4. out_ready=0; complete ch3 three times (0x01, 0x02, 0x03) -> out shows 0x01, hold[3]=0x02, 0x03 dropped, overflow=4'b1000. Raise ready -> 0x01 then 0x02 only.
5. in_valid=1, s=1, y=4'b0101 -> err=1 after that edge; the captured ch1 bit is 0. err stays 1 until rst.
6. Send 5 bits of ch0 as 1s, pulse rst for one cycle, then send 8 bits 0xF0 on ch0 -> out_data=0xF0, out_ch=0, no stale bits, overflow=0.

Source files
------------

// File: rtl/demux_deserializer_if.sv
// demux_deserializer_if
//   Bundles the sampled demux bus and the assembled-word output of the
//   demux deserializer.
//   in_valid  : y/s carry a valid bit this cycle
//   s         : channel select that was driven to the demux
//   y         : demux outputs, y[s] is the data bit
//   out_ready : downstream accepts the presented word
//   out_valid : out_ch/out_data valid
//   out_ch    : source channel of out_data
//   out_data  : assembled WIDTH-bit word
//   overflow  : sticky per-channel word-drop flags
//   err       : sticky demux protocol error
//   Modports: master drives the bit stream and ready, slave is the deserializer.
interface demux_deserializer_if #(parameter int WIDTH = 8);
  logic             in_valid;
  logic [1:0]       s;
  logic [3:0]       y;
  logic             out_ready;
  logic             out_valid;
  logic [1:0]       out_ch;
  logic [WIDTH-1:0] out_data;
  logic [3:0]       overflow;
  logic             err;

  modport master (
    output in_valid, s, y, out_ready,
    input  out_valid, out_ch, out_data, overflow, err
  );

  modport slave (
    input  in_valid, s, y, out_ready,
    output out_valid, out_ch, out_data, overflow, err
  );
endinterface

// File: rtl/demux_deserializer.sv
// demux_deserializer
//   Samples a 1x4 demux (y[3:0] with select s) and reassembles each channel's
//   serial stream, LSB first, into WIDTH-bit words. Each channel has a single
//   holding register; full words leave through one valid/ready output chosen
//   by a round-robin arbiter.
//   clk : rising-edge clock
//   rst : synchronous active-high reset
//   bus : demux_deserializer_if.slave (bit input, word output, flags)
module demux_deserializer #(
  parameter int WIDTH = 8
) (
  input logic                  clk,
  input logic                  rst,
  demux_deserializer_if.slave  bus
);

  localparam int CW = $clog2(WIDTH);

  logic [WIDTH-1:0] shift_q [4];
  logic [CW-1:0]    cnt_q   [4];
  logic [WIDTH-1:0] hold_q  [4];
  logic [3:0]       pend_q;
  logic [1:0]       rr_q;
  logic [3:0]       ov_q;
  logic             err_q;
  logic             out_valid_q;
  logic [1:0]       out_ch_q;
  logic [WIDTH-1:0] out_data_q;

  logic [CW-1:0]    cur_cnt;
  logic             cur_bit;
  logic             last_bit;
  logic [WIDTH-1:0] word;
  logic [1:0]       pick;
  logic [1:0]       idx;
  logic             any_pend;
  logic             load;
  logic [3:0]       pop_vec;
  logic [3:0]       set_vec;
  logic             accept;
  logic             drop;
  logic             err_hit;

  assign cur_cnt  = cnt_q[bus.s];
  assign cur_bit  = bus.y[bus.s];
  assign last_bit = bus.in_valid && (cur_cnt == CW'(WIDTH - 1));

  // Completed word: earlier bits from the shift register, top bit straight
  // from the bus so the word lands in hold on the same edge.
  always_comb begin
    word            = shift_q[bus.s];
    word[WIDTH-1]   = cur_bit;
  end

  // Round-robin: scan offsets from far to near so the nearest set bit
  // starting at rr wins.
  always_comb begin
    pick = '0;
    idx  = '0;
    for (int i = 3; i >= 0; i--) begin
      idx = rr_q + 2'(i);
      if (pend_q[idx]) pick = idx;
    end
  end

  assign any_pend = |pend_q;
  assign load     = !out_valid_q || bus.out_ready;
  assign pop_vec  = (load && any_pend) ? (4'b0001 << pick) : 4'b0000;

  // A pop of the same channel on this edge frees the holding register.
  assign accept  = last_bit && (!pend_q[bus.s] || pop_vec[bus.s]);
  assign drop    = last_bit && !accept;
  assign set_vec = accept ? (4'b0001 << bus.s) : 4'b0000;
  assign err_hit = bus.in_valid && |(bus.y & ~(4'b0001 << bus.s));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int c = 0; c < 4; c++) begin
        shift_q[c] <= '0;
        cnt_q[c]   <= '0;
        hold_q[c]  <= '0;
      end
      pend_q      <= '0;
      rr_q        <= '0;
      ov_q        <= '0;
      err_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      out_data_q  <= '0;
    end else begin
      if (bus.in_valid) begin
        shift_q[bus.s][cur_cnt] <= cur_bit;
        cnt_q[bus.s]            <= last_bit ? '0 : cur_cnt + 1'b1;
      end
      if (accept) hold_q[bus.s] <= word;
      if (drop)   ov_q[bus.s]   <= 1'b1;
      if (err_hit) err_q        <= 1'b1;
      pend_q <= (pend_q & ~pop_vec) | set_vec;

      if (load) begin
        if (any_pend) begin
          out_valid_q <= 1'b1;
          out_ch_q    <= pick;
          out_data_q  <= hold_q[pick];
          rr_q        <= pick + 2'd1;
        end else begin
          out_valid_q <= 1'b0;
        end
      end
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_ch    = out_ch_q;
  assign bus.out_data  = out_data_q;
  assign bus.overflow  = ov_q;
  assign bus.err       = err_q;

endmodule
